// File: rtl/pipe_stage_buf_pkg.sv
// Shared types and defaults for the pipeline stage buffer and its slots.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // IS, PC, RA, RB, R at 32 bits plus three 5-bit register fields
  localparam int unsigned DATA_W_DEF = 175;
  localparam int unsigned CTRL_W_DEF = 23;

  localparam logic [CTRL_W_DEF-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready payload channel between two pipeline stages.
interface pipe_stage_buf_if
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CTRL_W = CTRL_W_DEF
);

  logic              in_valid;
  logic              out_ready_up;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              in_ready_dn;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  modport slave (
    input  in_valid, in_data, in_ctrl, in_ready_dn,
    output out_ready_up, out_valid, out_data, out_ctrl
  );

  modport master (
    output in_valid, in_data, in_ctrl, in_ready_dn,
    input  out_ready_up, out_valid, out_data, out_ctrl
  );

endinterface

// File: rtl/pipe_stage_buf_slot.sv
// One storage slot: payload plus control word with load, bubble and flush.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              bubble,
  input  logic              flush,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CTRL_W-1:0] load_ctrl,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  // Bubble only neutralises the control word; flush wipes the payload as well.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      ctrl <= CTRL_W'(CTRL_NOP);
    end else if (flush) begin
      data <= '0;
      ctrl <= CTRL_W'(CTRL_NOP);
    end else if (load) begin
      data <= load_data;
      ctrl <= load_ctrl;
    end else if (bubble) begin
      ctrl <= CTRL_W'(CTRL_NOP);
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with 2-entry skid buffer, flush, stall and stall counter.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             in_CLK,
  input  logic             in_CLR_N,
  input  logic             in_EN,
  input  logic             in_flush,
  pipe_stage_buf_if.slave  bus,
  output logic [CNT_W-1:0] out_stall_cnt
);

  state_t            state;
  logic              ready;
  logic              valid;
  logic              accept;
  logic              pop;
  logic              head_load;
  logic              head_bubble;
  logic              skid_load;
  logic              skid_bubble;
  logic [DATA_W-1:0] head_data;
  logic [CTRL_W-1:0] head_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] head_in_data;
  logic [CTRL_W-1:0] head_in_ctrl;

  // Ready comes only from registered state, so no path from in_ready_dn.
  assign ready  = in_EN & ~in_flush & (state != FULL);
  assign valid  = (state != EMPTY) & ~in_flush;
  assign accept = bus.in_valid & ready;
  assign pop    = valid & bus.in_ready_dn & in_EN;

  always_comb begin
    head_load   = 1'b0;
    head_bubble = 1'b0;
    skid_load   = 1'b0;
    skid_bubble = 1'b0;
    case (state)
      EMPTY: head_load = accept;
      ONE: begin
        head_load   = accept & pop;
        skid_load   = accept & ~pop;
        head_bubble = ~accept & pop;
      end
      FULL: begin
        head_load   = pop;
        skid_bubble = pop;
      end
      default: ;
    endcase
  end

  assign head_in_data = (state == FULL) ? skid_data : bus.in_data;
  assign head_in_ctrl = (state == FULL) ? skid_ctrl : bus.in_ctrl;

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_head (
    .clk       (in_CLK),
    .rst_n     (in_CLR_N),
    .load      (head_load),
    .bubble    (head_bubble),
    .flush     (in_flush),
    .load_data (head_in_data),
    .load_ctrl (head_in_ctrl),
    .data      (head_data),
    .ctrl      (head_ctrl)
  );

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clk       (in_CLK),
    .rst_n     (in_CLR_N),
    .load      (skid_load),
    .bubble    (skid_bubble),
    .flush     (in_flush),
    .load_data (bus.in_data),
    .load_ctrl (bus.in_ctrl),
    .data      (skid_data),
    .ctrl      (skid_ctrl)
  );

  always_ff @(posedge in_CLK or negedge in_CLR_N) begin
    if (!in_CLR_N) begin
      state <= EMPTY;
    end else if (in_flush) begin
      state <= EMPTY;
    end else if (in_EN) begin
      case (state)
        EMPTY: if (accept) state <= ONE;
        ONE: begin
          if (accept & ~pop)      state <= FULL;
          else if (~accept & pop) state <= EMPTY;
        end
        FULL:    if (pop) state <= ONE;
        default: state <= EMPTY;
      endcase
    end
  end

  always_ff @(posedge in_CLK or negedge in_CLR_N) begin
    if (!in_CLR_N) begin
      out_stall_cnt <= '0;
    end else if ((state != EMPTY) && in_EN && !in_flush && !bus.in_ready_dn
                 && (out_stall_cnt != '1)) begin
      out_stall_cnt <= out_stall_cnt + 1'b1;
    end
  end

  assign bus.out_ready_up = ready;
  assign bus.out_valid    = valid;
  assign bus.out_data     = head_data;
  assign bus.out_ctrl     = head_ctrl;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: vector table, scoreboard and corner-case sequences.
module tb_pipe_stage_buf;
  import pipe_pkg::*;

  localparam int unsigned DW = DATA_W_DEF;
  localparam int unsigned CW = CTRL_W_DEF;
  localparam int unsigned NW = 16;
  localparam int unsigned SW = 4;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  logic en = 1'b0;
  logic flush = 1'b0;
  logic [NW-1:0] stall_cnt;
  logic [SW-1:0] small_cnt;

  always #5 clk = ~clk;

  pipe_stage_buf_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();
  pipe_stage_buf_if #(.DATA_W(DW), .CTRL_W(CW)) sbus ();

  pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .in_CLK        (clk),
    .in_CLR_N      (clr_n),
    .in_EN         (en),
    .in_flush      (flush),
    .bus           (bus),
    .out_stall_cnt (stall_cnt)
  );

  pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(SW)) dut_small (
    .in_CLK        (clk),
    .in_CLR_N      (clr_n),
    .in_EN         (en),
    .in_flush      (flush),
    .bus           (sbus),
    .out_stall_cnt (small_cnt)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;
  } ent_t;

  typedef struct packed {
    logic e, f, v, r;
    logic [7:0] d;
    logic xr, xv;
    logic [7:0] xd;
    logic xz;
    logic [15:0] xc;
  } vec_t;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned m_cnt = 0;
  ent_t sb[$];
  vec_t vecs[20];
  logic s_ready, s_valid;
  logic [DW-1:0] s_data;
  logic [CW-1:0] s_ctrl;

  function automatic logic [DW-1:0] data_of(input logic [7:0] d);
    data_of = '0;
    data_of[7:0] = d;
    data_of[DW-1 -: 8] = ~d;
  endfunction

  function automatic logic [CW-1:0] ctrl_of(input logic [7:0] d);
    ctrl_of = '0;
    ctrl_of[7:0] = d;
    ctrl_of[CW-1] = 1'b1;
  endfunction

  function automatic vec_t mk(input logic e, f, v, r, input logic [7:0] d,
                              input logic xr, xv, input logic [7:0] xd,
                              input logic xz, input logic [15:0] xc);
    mk = '{e, f, v, r, d, xr, xv, xd, xz, xc};
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive, sample at negedge against the queue model, advance.
  task automatic cycle(input logic e, f, v, r, input logic [7:0] d);
    logic m_ready, m_valid;
    ent_t x;
    en = e;
    flush = f;
    bus.in_valid = v;
    bus.in_ready_dn = r;
    bus.in_data = data_of(d);
    bus.in_ctrl = ctrl_of(d);
    @(negedge clk);
    m_ready = e & ~f & (sb.size() < 2);
    m_valid = (sb.size() != 0) & ~f;
    s_ready = bus.out_ready_up;
    s_valid = bus.out_valid;
    s_data = bus.out_data;
    s_ctrl = bus.out_ctrl;
    check("sb_ready", DW'(s_ready), DW'(m_ready));
    check("sb_valid", DW'(s_valid), DW'(m_valid));
    if (!f && e && sb.size() != 0 && !r && m_cnt != 65535) m_cnt++;
    if (f) begin
      sb.delete();
    end else begin
      if (m_valid && r && e) begin
        x = sb.pop_front();
        check("sb_data", s_data, x.data);
        check("sb_ctrl", DW'(s_ctrl), DW'(x.ctrl));
      end
      if (v && m_ready) begin
        x.data = data_of(d);
        x.ctrl = ctrl_of(d);
        sb.push_back(x);
      end
    end
    @(posedge clk);
    #1;
    check("sb_stall_cnt", DW'(stall_cnt), DW'(m_cnt));
  endtask

  initial begin
    //            e f v r  d      rdy vld xd     z  cnt
    vecs[0]  = mk(H, L, H, L, 8'h0A, H, L, 8'h00, L, 16'd0);
    vecs[1]  = mk(H, L, H, L, 8'h0B, H, H, 8'h0A, L, 16'd1);
    vecs[2]  = mk(H, L, L, L, 8'h00, L, H, 8'h0A, L, 16'd2);
    vecs[3]  = mk(H, L, L, L, 8'h00, L, H, 8'h0A, L, 16'd3);
    vecs[4]  = mk(H, L, L, L, 8'h00, L, H, 8'h0A, L, 16'd4);
    vecs[5]  = mk(H, L, L, L, 8'h00, L, H, 8'h0A, L, 16'd5);
    vecs[6]  = mk(H, L, L, L, 8'h00, L, H, 8'h0A, L, 16'd6);
    vecs[7]  = mk(H, L, L, H, 8'h00, L, H, 8'h0A, L, 16'd6);
    vecs[8]  = mk(H, L, L, H, 8'h00, H, H, 8'h0B, L, 16'd6);
    vecs[9]  = mk(H, L, L, H, 8'h00, H, L, 8'h00, L, 16'd6);
    vecs[10] = mk(H, L, H, L, 8'h21, H, L, 8'h00, L, 16'd6);
    vecs[11] = mk(H, L, H, L, 8'h22, H, H, 8'h21, L, 16'd7);
    vecs[12] = mk(H, H, H, L, 8'h0C, L, L, 8'h00, L, 16'd7);
    vecs[13] = mk(H, L, L, H, 8'h00, H, L, 8'h00, H, 16'd7);
    vecs[14] = mk(H, L, H, L, 8'h05, H, L, 8'h00, L, 16'd7);
    vecs[15] = mk(L, L, H, H, 8'h06, L, H, 8'h05, L, 16'd7);
    vecs[16] = mk(L, L, H, H, 8'h06, L, H, 8'h05, L, 16'd7);
    vecs[17] = mk(L, L, H, H, 8'h06, L, H, 8'h05, L, 16'd7);
    vecs[18] = mk(H, L, L, H, 8'h00, H, H, 8'h05, L, 16'd7);
    vecs[19] = mk(H, L, L, H, 8'h00, H, L, 8'h00, L, 16'd7);

    bus.in_valid = 1'b0;
    bus.in_ready_dn = 1'b1;
    bus.in_data = '0;
    bus.in_ctrl = '0;
    sbus.in_valid = 1'b0;
    sbus.in_ready_dn = 1'b1;
    sbus.in_data = '0;
    sbus.in_ctrl = '0;

    // Power-on reset: ready tracks in_EN, everything else zero.
    #1;
    check("rst_ready_en0", DW'(bus.out_ready_up), DW'(1'b0));
    en = 1'b1;
    #1;
    check("rst_ready_en1", DW'(bus.out_ready_up), DW'(1'b1));
    check("rst_valid", DW'(bus.out_valid), DW'(1'b0));
    check("rst_data", bus.out_data, '0);
    check("rst_ctrl", DW'(bus.out_ctrl), '0);
    check("rst_cnt", DW'(stall_cnt), '0);
    @(posedge clk);
    #1;
    clr_n = 1'b1;

    // Streaming 1..10 at full rate, then drain.
    for (int i = 1; i <= 10; i++) cycle(H, L, H, H, 8'(i));
    cycle(H, L, L, H, 8'h00);
    cycle(H, L, L, H, 8'h00);

    // Back-pressure, flush and enable vectors.
    for (int i = 0; i < 20; i++) begin
      cycle(vecs[i].e, vecs[i].f, vecs[i].v, vecs[i].r, vecs[i].d);
      check($sformatf("vec%0d_ready", i), DW'(s_ready), DW'(vecs[i].xr));
      check($sformatf("vec%0d_valid", i), DW'(s_valid), DW'(vecs[i].xv));
      if (vecs[i].xv) begin
        check($sformatf("vec%0d_data", i), s_data, data_of(vecs[i].xd));
        check($sformatf("vec%0d_ctrl", i), DW'(s_ctrl), DW'(ctrl_of(vecs[i].xd)));
      end
      if (vecs[i].xz) begin
        check($sformatf("vec%0d_data_zero", i), s_data, '0);
        check($sformatf("vec%0d_ctrl_zero", i), DW'(s_ctrl), '0);
      end
      check($sformatf("vec%0d_cnt", i), DW'(stall_cnt), DW'(vecs[i].xc));
    end

    // Asynchronous reset while FULL.
    cycle(H, L, H, L, 8'h31);
    cycle(H, L, H, L, 8'h32);
    check("full_ready_low", DW'(bus.out_ready_up), DW'(1'b0));
    bus.in_valid = 1'b0;
    #3;
    clr_n = 1'b0;
    #1;
    check("mid_rst_valid", DW'(bus.out_valid), DW'(1'b0));
    check("mid_rst_data", bus.out_data, '0);
    check("mid_rst_ctrl", DW'(bus.out_ctrl), '0);
    check("mid_rst_cnt", DW'(stall_cnt), '0);
    sb.delete();
    m_cnt = 0;
    @(posedge clk);
    #1;
    clr_n = 1'b1;
    #1;
    check("rel_ready", DW'(bus.out_ready_up), DW'(1'b1));
    check("rel_valid", DW'(bus.out_valid), DW'(1'b0));
    cycle(H, L, H, H, 8'h41);
    cycle(H, L, L, H, 8'h00);

    // Counter saturation on the 4-bit instance.
    sbus.in_valid = 1'b1;
    sbus.in_ready_dn = 1'b0;
    sbus.in_data = data_of(8'h77);
    sbus.in_ctrl = ctrl_of(8'h77);
    @(posedge clk);
    #1;
    sbus.in_valid = 1'b0;
    check("sat_start", DW'(small_cnt), '0);
    for (int k = 1; k <= 21; k++) begin
      @(posedge clk);
      #1;
      if (k == 10) check("sat_k10", DW'(small_cnt), DW'(4'd10));
      if (k == 15) check("sat_k15", DW'(small_cnt), DW'(4'd15));
      if (k >= 20) check($sformatf("sat_k%0d", k), DW'(small_cnt), DW'(4'd15));
    end
    check("sat_valid", DW'(sbus.out_valid), DW'(1'b1));
    check("sat_data", sbus.out_data, data_of(8'h77));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised pipeline-stage register, the successor to the fixed-width inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque payload plus a control word with a valid/ready handshake and a 2-entry skid buffer, so the stage sustains full throughput under back-pressure.
- Adds synchronous flush (bubble insertion), a global enable (stall), and a saturating back-pressure cycle counter for performance debug.

Parameters:
- DATA_W, 175, payload width (default = IS, PC, RA, RB, R at 32 bits each, plus three 5-bit register fields).
- CTRL_W, 23, control-word width; all-zero control word = NOP bubble.
- CNT_W, 16, width of the stall counter.

Ports:
- in_CLK  input  1  clock, rising edge.
- in_CLR_N  input  1  asynchronous, active-low reset.
- in_EN  input  1  global enable; low freezes all state.
- in_flush  input  1  synchronous flush; discards all held entries.
- in_valid  input  1  upstream has data.
- out_ready_up  output  1  stage can accept data this cycle.
- in_data  input  DATA_W  upstream payload.
- in_ctrl  input  CTRL_W  upstream control word.
- out_valid  output  1  stage presents data downstream.
- in_ready_dn  input  1  downstream can accept.
- out_data  output  DATA_W  head payload.
- out_ctrl  output  CTRL_W  head control word.
- out_stall_cnt  output  CNT_W  saturating back-pressure cycle count.

Behaviour:
- Storage: head slot (drives out_data/out_ctrl) and skid slot. Occupancy state is EMPTY, ONE, or FULL.
- Reset (in_CLR_N=0, asynchronous):
  - state=EMPTY; both slots' data and ctrl = 0; out_stall_cnt=0.
  - Outputs: out_valid=0, out_data=0, out_ctrl=0. out_ready_up follows in_EN (combinational).
- Handshake terms:
  - out_ready_up = in_EN & ~in_flush & (state!=FULL).
  - out_valid = (state!=EMPTY) & ~in_flush.
  - accept = in_valid & out_ready_up.
  - pop = out_valid & in_ready_dn & in_EN.
- Priority per edge: flush, then in_EN=0 (hold), then the normal transitions below.
- Flush: state goes to EMPTY; both slots' ctrl = 0 and data = 0. Same-cycle input is dropped; no pop occurs. Ignores in_EN.
- Normal transitions:
  - EMPTY: accept -> ONE, head <= in.
  - ONE: accept & pop -> ONE, head <= in. accept & ~pop -> FULL, skid <= in. ~accept & pop -> EMPTY, head ctrl <= 0. Otherwise hold.
  - FULL: pop -> ONE, head <= skid, skid ctrl <= 0. Otherwise hold. Accept is impossible (ready low).
- Latency: 1 cycle from accept to out_valid when EMPTY. Throughput is 1 transfer/cycle with in_ready_dn held high.
- Ordering: strict FIFO; no drops except on flush.
- Payload stability: out_data and out_ctrl are unchanged while out_valid=1 and no pop occurs.
- out_ready_up depends only on registered state, in_EN, and in_flush; there is no combinational path from in_ready_dn.
- Stall counter: +1 per edge when state!=EMPTY & in_EN & ~in_flush & ~in_ready_dn. Saturates at 2^CNT_W-1. Cleared only by reset; flush does not clear it.

Decomposition:
- Package pipe_pkg holds:
  - state enum: EMPTY=2'd0, ONE=2'd1, FULL=2'd2;
  - default width constants (DATA_W_DEF, CTRL_W_DEF);
  - CTRL_NOP = '0.
- One sub-module, pipe_slot: load-enabled register of DATA_W+CTRL_W bits with async active-low clear and a synchronous bubble input. Instantiated twice (head, skid).
- The FSM and counter live in the top module.

Test Plan:
- Reset: hold in_CLR_N=0 mid-stream with state FULL -> out_valid=0, out_data=0, out_ctrl=0, out_stall_cnt=0 immediately (asynchronous). Release with in_EN=1 -> out_ready_up=1.
- Streaming: in_EN=1, in_ready_dn=1, in_valid=1 with data 1,2,3,...,10 on consecutive cycles -> out_data 1..10 one cycle later, out_valid continuous, out_ready_up never low.
- Back-pressure: in_ready_dn=0, push A=0xA, B=0xB -> after the second accept out_ready_up=0 and out_stall_cnt rises by 1/cycle. Hold 5 cycles, then in_ready_dn=1 -> 0xA then 0xB on consecutive cycles, state EMPTY after.
- Flush: in state FULL, assert in_flush for 1 cycle with in_valid=1, data 0xC -> out_valid=0 in the flush cycle, state EMPTY next cycle, out_ctrl=0, 0xC never emitted.
- Enable: in_EN=0 for 3 cycles with in_valid=1, in_ready_dn=1, state ONE holding 0x5 -> out_ready_up=0, no pop, out_data stays 0x5, counter unchanged.
- Saturation: CNT_W=4, hold ONE with in_ready_dn=0 for 20 cycles -> out_stall_cnt=15 and stays 15.
